// File: rtl/lcd_hex_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lcd_hex_frame_ctrl
// Purpose  : HD44780 16x2 LCD controller. Runs the power-up initialisation
//            sequence, then on request converts NUM_DIGITS packed hex nibbles
//            to upper-case ASCII and writes them starting at (ROW, START_COL).
//            A load/busy handshake with a one-deep pending flag lets requests
//            made while busy start a fresh frame as soon as the LCD is free.
// Ports    : iCLK      - system clock
//            iRST_N    - asynchronous active-low reset
//            iDIGITS   - packed nibbles, [4*NUM_DIGITS-1 -: 4] is leftmost
//            iLOAD     - one-cycle request to display iDIGITS
//            oBUSY     - high while initialising or writing a frame
//            oREADY    - sticky high once initialisation has completed
//            LCD_DATA  - LCD data bus (write-only, always driven)
//            LCD_RS    - 0 = command, 1 = data
//            LCD_RW    - tied low
//            LCD_E     - LCD enable strobe
// Options  : define LCD_AUTO_REFRESH_EN to start a frame automatically
//            whenever iDIGITS differs from the last displayed value.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_hex_frame_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int ROW        = 0,
    parameter int START_COL  = 0,
    parameter int E_CYCLES   = 16,
    parameter int CMD_WAIT   = 2000,
    parameter int CLR_WAIT   = 100000,
    parameter int PWRUP_WAIT = 750000
) (
    input  logic                    iCLK,
    input  logic                    iRST_N,
    input  logic [4*NUM_DIGITS-1:0] iDIGITS,
    input  logic                    iLOAD,
    output logic                    oBUSY,
    output logic                    oREADY,
    output logic [7:0]              LCD_DATA,
    output logic                    LCD_RS,
    output logic                    LCD_RW,
    output logic                    LCD_E
);

    // One shared down-counter covers every timed interval, so size it for the
    // longest of them.
    localparam int c_MAX_A   = (PWRUP_WAIT > CLR_WAIT) ? PWRUP_WAIT : CLR_WAIT;
    localparam int c_MAX_B   = (CMD_WAIT > E_CYCLES) ? CMD_WAIT : E_CYCLES;
    localparam int c_MAX     = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_CNT_W   = $clog2(c_MAX + 1);
    localparam logic [7:0] c_ADDR_CMD = 8'h80 | 8'(ROW * 64 + START_COL);

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_INIT  = 3'd1,
        ST_IDLE  = 3'd2,
        ST_ADDR  = 3'd3,
        ST_CHAR  = 3'd4
    } state_t;

    // Per-byte write phases shared by INIT, ADDR and CHAR.
    typedef enum logic [1:0] {
        PH_SETUP = 2'd0,
        PH_EHIGH = 2'd1,
        PH_HOLD  = 2'd2,
        PH_WAIT  = 2'd3
    } phase_t;

    state_t                    r_state, w_state_nxt;
    phase_t                    r_phase, w_phase_nxt;
    logic [c_CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic [4:0]                r_idx, w_idx_nxt;
    logic                      r_pending, w_pending_nxt;
    logic [4*NUM_DIGITS-1:0]   r_shadow, w_shadow_nxt;
    logic                      r_ready, w_ready_nxt;
    logic                      r_lcd_e, w_lcd_e_nxt;
    logic                      r_lcd_rs, w_lcd_rs_nxt;
    logic [7:0]                r_lcd_data, w_lcd_data_nxt;

    logic                      w_auto_req;
    logic                      w_writing_nxt;
    logic [c_CNT_W-1:0]        w_wait_last;
    logic [7:0]                w_shamt;
    logic [4*NUM_DIGITS-1:0]   w_shifted;
    logic [3:0]                w_nibble;
    logic [7:0]                w_ascii;
    logic [7:0]                w_init_byte;
    logic [7:0]                w_byte_nxt;

`ifdef LCD_AUTO_REFRESH_EN
    assign w_auto_req = (iDIGITS != r_shadow);
`else
    assign w_auto_req = 1'b0;
`endif

    // The clear command (fourth init byte) needs the long settle time.
    assign w_wait_last = (r_state == ST_INIT && r_idx == 5'd3) ?
                         c_CNT_W'(CLR_WAIT - 1) : c_CNT_W'(CMD_WAIT - 1);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_pending_nxt = r_pending;
        w_shadow_nxt  = r_shadow;
        w_ready_nxt   = r_ready;

        // Any request arriving while not idle (including the cycle that
        // re-enters IDLE) is remembered, never captured immediately.
        if (r_state != ST_IDLE && iLOAD) begin
            w_pending_nxt = 1'b1;
        end

        case (r_state)
            ST_PWRUP: begin
                if (r_cnt == c_CNT_W'(PWRUP_WAIT - 1)) begin
                    w_state_nxt = ST_INIT;
                    w_phase_nxt = PH_SETUP;
                    w_idx_nxt   = 5'd0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (r_pending || iLOAD || w_auto_req) begin
                    w_state_nxt   = ST_ADDR;
                    w_phase_nxt   = PH_SETUP;
                    w_cnt_nxt     = '0;
                    w_shadow_nxt  = iDIGITS;
                    w_pending_nxt = 1'b0;
                end
            end
            default: begin
                case (r_phase)
                    PH_SETUP: begin
                        w_phase_nxt = PH_EHIGH;
                        w_cnt_nxt   = '0;
                    end
                    PH_EHIGH: begin
                        if (r_cnt == c_CNT_W'(E_CYCLES - 1)) begin
                            w_phase_nxt = PH_HOLD;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + c_CNT_W'(1);
                        end
                    end
                    PH_HOLD: begin
                        w_phase_nxt = PH_WAIT;
                        w_cnt_nxt   = '0;
                    end
                    default: begin
                        if (r_cnt == w_wait_last) begin
                            w_cnt_nxt   = '0;
                            w_phase_nxt = PH_SETUP;
                            if (r_state == ST_INIT) begin
                                if (r_idx == 5'd4) begin
                                    w_state_nxt = ST_IDLE;
                                    w_ready_nxt = 1'b1;
                                    w_idx_nxt   = 5'd0;
                                end else begin
                                    w_idx_nxt = r_idx + 5'd1;
                                end
                            end else if (r_state == ST_ADDR) begin
                                w_state_nxt = ST_CHAR;
                                w_idx_nxt   = 5'd0;
                            end else if (r_idx == 5'(NUM_DIGITS - 1)) begin
                                w_state_nxt = ST_IDLE;
                                w_idx_nxt   = 5'd0;
                            end else begin
                                w_idx_nxt = r_idx + 5'd1;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + c_CNT_W'(1);
                        end
                    end
                endcase
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Byte selection for the write that is about to start
    // ------------------------------------------------------------------
    assign w_shamt   = 8'(4 * (NUM_DIGITS - 1)) - {1'b0, w_idx_nxt, 2'b00};
    assign w_shifted = w_shadow_nxt >> w_shamt;
    assign w_nibble  = w_shifted[3:0];
    assign w_ascii   = (w_nibble < 4'd10) ? (8'h30 + {4'h0, w_nibble})
                                          : (8'h37 + {4'h0, w_nibble});

    always_comb begin
        w_init_byte = 8'h00;
        case (w_idx_nxt)
            5'd0, 5'd1: w_init_byte = 8'h38;
            5'd2:       w_init_byte = 8'h0C;
            5'd3:       w_init_byte = 8'h01;
            5'd4:       w_init_byte = 8'h06;
            default:    w_init_byte = 8'h00;
        endcase
    end

    always_comb begin
        w_byte_nxt     = w_ascii;
        w_writing_nxt  = (w_state_nxt == ST_INIT) || (w_state_nxt == ST_ADDR) ||
                         (w_state_nxt == ST_CHAR);
        w_lcd_data_nxt = r_lcd_data;
        w_lcd_rs_nxt   = r_lcd_rs;
        if (w_state_nxt == ST_INIT) begin
            w_byte_nxt = w_init_byte;
        end else if (w_state_nxt == ST_ADDR) begin
            w_byte_nxt = c_ADDR_CMD;
        end
        // DATA/RS only move on entry to SETUP, so they are stable across the
        // whole E pulse and the following HOLD cycle.
        if (w_writing_nxt && w_phase_nxt == PH_SETUP) begin
            w_lcd_data_nxt = w_byte_nxt;
            w_lcd_rs_nxt   = (w_state_nxt == ST_CHAR);
        end
        w_lcd_e_nxt = w_writing_nxt && (w_phase_nxt == PH_EHIGH);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state    <= ST_PWRUP;
            r_phase    <= PH_WAIT;
            r_cnt      <= '0;
            r_idx      <= 5'd0;
            r_pending  <= 1'b0;
            r_shadow   <= '0;
            r_ready    <= 1'b0;
            r_lcd_e    <= 1'b0;
            r_lcd_rs   <= 1'b0;
            r_lcd_data <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_pending  <= w_pending_nxt;
            r_shadow   <= w_shadow_nxt;
            r_ready    <= w_ready_nxt;
            r_lcd_e    <= w_lcd_e_nxt;
            r_lcd_rs   <= w_lcd_rs_nxt;
            r_lcd_data <= w_lcd_data_nxt;
        end
    end

    assign oBUSY    = (r_state != ST_IDLE);
    assign oREADY   = r_ready;
    assign LCD_DATA = r_lcd_data;
    assign LCD_RS   = r_lcd_rs;
    assign LCD_RW   = 1'b0;
    assign LCD_E    = r_lcd_e;

endmodule
`default_nettype wire

// File: tb/tb_lcd_hex_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_hex_frame_ctrl
// Purpose  : Self-checking bench for lcd_hex_frame_ctrl. A timing model
//            schedules the expected E strobes and busy/ready levels from the
//            controller's documented behaviour; directed scenarios add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lcd_hex_frame_ctrl;

    localparam int N    = 6;
    localparam int ROW  = 1;
    localparam int COL  = 4;
    localparam int EC   = 2;
    localparam int CW   = 5;
    localparam int CLR  = 20;
    localparam int PW   = 10;
    localparam int P    = EC + 2 + CW;                 // clocks per normal byte
    localparam int INIT_LEN = PW + 4 * P + (EC + 2 + CLR);
    localparam int F    = (1 + N) * P;                 // frame length

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] digits = 24'h0;
    logic        load = 1'b0;
    logic        busy, ready, rs, rw, e;
    logic [7:0]  data;

    logic [3:0]  digits1 = 4'h0;
    logic        load1 = 1'b0;
    logic        busy1, ready1, rs1, rw1, e1;
    logic [7:0]  data1;

    always #5 clk = ~clk;

    lcd_hex_frame_ctrl #(
        .NUM_DIGITS(N), .ROW(ROW), .START_COL(COL), .E_CYCLES(EC),
        .CMD_WAIT(CW), .CLR_WAIT(CLR), .PWRUP_WAIT(PW)
    ) dut (
        .iCLK(clk), .iRST_N(rst_n), .iDIGITS(digits), .iLOAD(load),
        .oBUSY(busy), .oREADY(ready), .LCD_DATA(data), .LCD_RS(rs),
        .LCD_RW(rw), .LCD_E(e)
    );

    lcd_hex_frame_ctrl #(
        .NUM_DIGITS(1), .ROW(0), .START_COL(15), .E_CYCLES(EC),
        .CMD_WAIT(CW), .CLR_WAIT(CLR), .PWRUP_WAIT(PW)
    ) dut1 (
        .iCLK(clk), .iRST_N(rst_n), .iDIGITS(digits1), .iLOAD(load1),
        .oBUSY(busy1), .oREADY(ready1), .LCD_DATA(data1), .LCD_RS(rs1),
        .LCD_RW(rw1), .LCD_E(e1)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: expected strobes with absolute rise cycles
    // ------------------------------------------------------------------
    typedef struct {
        int         rise;
        logic [7:0] bdata;
        logic       brs;
    } strobe_t;

    strobe_t     mq[$];
    int          cyc = 0;
    int          e1_cyc = 0;
    int          m_left = INIT_LEN;
    logic        m_pend = 1'b0;
    logic        m_ready = 1'b0;
    logic        m_in_init = 1'b1;
    logic        m_start_init = 1'b1;
    logic [23:0] m_shadow = 24'h0;
    logic [7:0]  init_bytes [5] = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + 8'(n);
        return 8'h41 + 8'(n - 4'd10);   // 'A' onwards
    endfunction

    task automatic push_init(input int base);
        int r = base + PW;
        for (int k = 0; k < 5; k++) begin
            mq.push_back('{r, init_bytes[k], 1'b0});
            r += EC + 2 + ((init_bytes[k] == 8'h01) ? CLR : CW);
        end
    endtask

    task automatic push_frame(input int t0, input logic [23:0] d);
        int r = t0 + 1;
        mq.push_back('{r, 8'h80 + 8'(ROW * 64 + COL), 1'b0});
        for (int i = 0; i < N; i++) begin
            r += P;
            mq.push_back('{r, hex_ascii(d[4*(N-1-i) +: 4]), 1'b1});
        end
    endtask

    initial begin : model
        logic auto_diff;
        forever begin
            @(posedge clk);
            cyc++;
`ifdef LCD_AUTO_REFRESH_EN
            auto_diff = (digits != m_shadow);
`else
            auto_diff = 1'b0;
`endif
            if (!rst_n) begin
                mq.delete();
                m_left = INIT_LEN; m_pend = 1'b0; m_ready = 1'b0;
                m_in_init = 1'b1; m_start_init = 1'b1; m_shadow = 24'h0;
            end else begin
                if (m_start_init) begin
                    push_init(cyc);
                    e1_cyc = cyc;
                    m_start_init = 1'b0;
                end
                if (m_left > 0) begin
                    if (load) m_pend = 1'b1;
                    m_left--;
                    if (m_left == 0 && m_in_init) begin
                        m_ready = 1'b1;
                        m_in_init = 1'b0;
                    end
                end else if (m_pend || load || auto_diff) begin
                    m_shadow = digits;
                    push_frame(cyc, digits);
                    m_left = F;
                    m_pend = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare against the model (main DUT)
    // ------------------------------------------------------------------
    initial begin : compare
        logic exp_e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_e", e, 1'b0);
                check("rst_busy", busy, 1'b1);
                check("rst_ready", ready, 1'b0);
                check("rst_data", data, 8'h00);
                check("rst_rs", rs, 1'b0);
            end else begin
                while (mq.size() > 0 && cyc >= mq[0].rise + EC) void'(mq.pop_front());
                exp_e = (mq.size() > 0) && (cyc >= mq[0].rise);
                check("lcd_e", e, exp_e);
                if (exp_e) begin
                    check("lcd_data", data, mq[0].bdata);
                    check("lcd_rs", rs, mq[0].brs);
                end
                check("busy", busy, (m_left != 0));
                check("ready", ready, m_ready);
                check("rw", rw, 1'b0);
                check("rw1", rw1, 1'b0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Strobe log and busy-run measurement used by literal checks
    // ------------------------------------------------------------------
    logic [7:0] log_d[$];
    logic       log_rs[$];
    int         log_t[$];
    logic [7:0] log1_d[$];
    logic       log1_rs[$];
    int         last_busy_len = 0;
    int         last_busy1_len = 0;

    initial begin : monitor
        logic pe, pe1;
        int run, run1;
        pe = 1'b0; pe1 = 1'b0; run = 0; run1 = 0;
        forever begin
            @(negedge clk);
            if (e && !pe) begin
                log_d.push_back(data); log_rs.push_back(rs); log_t.push_back(cyc);
            end
            if (e1 && !pe1) begin
                log1_d.push_back(data1); log1_rs.push_back(rs1);
            end
            pe = e; pe1 = e1;
            if (busy) run++;
            else if (run > 0) begin last_busy_len = run; run = 0; end
            if (busy1) run1++;
            else if (run1 > 0) begin last_busy1_len = run1; run1 = 0; end
        end
    end

    // Wait until the main DUT has been idle for three consecutive cycles.
    task automatic settle(input string nm);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < 600) begin
            @(negedge clk);
            n++;
            if (ready && !busy) quiet++;
            else quiet = 0;
        end
        check(nm, quiet >= 3, 1'b1);
    endtask

    task automatic pulse_load();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    logic [8:0] exp_f2 [7] = '{9'h0C4, 9'h130, 9'h139, 9'h141, 9'h146, 9'h131, 9'h132};

    task automatic check_init_log(input string nm);
        check({nm, "_count"}, log_d.size(), 5);
        for (int k = 0; k < 5 && k < log_d.size(); k++) begin
            check({nm, "_byte"}, {log_rs[k], log_d[k]}, {1'b0, init_bytes[k]});
        end
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        int n;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: power-up and init sequence
        settle("init_done");
        check_init_log("init");
        if (log_t.size() >= 5) begin
            check("first_e_cycle", log_t[0] - e1_cyc + 1, 11);
            check("clear_gap", log_t[4] - log_t[3], EC + 2 + CLR);
        end
        check("ready_after_init", ready, 1'b1);
        check("busy_after_init", busy, 1'b0);

        // 2: one frame at row 1, column 4
        log_d.delete(); log_rs.delete(); log_t.delete();
        digits = 24'h09AF12;
        pulse_load();
        settle("f2_done");
        check("f2_count", log_d.size(), 7);
        for (int k = 0; k < 7 && k < log_d.size(); k++)
            check("f2_byte", {log_rs[k], log_d[k]}, exp_f2[k]);
        check("f2_busy_len", last_busy_len, 63);

        // 3: requests while busy collapse into one frame with fresh data
        log_d.delete(); log_rs.delete(); log_t.delete();
        digits = 24'h111111;
        pulse_load();
        repeat (10) @(negedge clk);
        pulse_load();
        repeat (5) @(negedge clk);
        pulse_load();
        digits = 24'h222222;
        settle("f3_done");
        repeat (20) @(negedge clk);
        check("f3_count", log_d.size(), 14);
        if (log_d.size() >= 14) begin
            check("f3_first_char", log_d[1], 8'h31);
            check("f3_addr2", log_d[7], 8'hC4);
            for (int k = 8; k < 14; k++) check("f3_char2", log_d[k], 8'h32);
        end

        // 4: reset during the E pulse of character 3 aborts the write
        log_d.delete(); log_rs.delete(); log_t.delete();
        digits = 24'h456789;
        pulse_load();
        n = 0;
        while (log_d.size() < 5 && n < 300) begin @(negedge clk); n++; end
        check("f4_reach_char3", log_d.size(), 5);
        check("f4_e_high", e, 1'b1);
        #1;
        rst_n = 1'b0;
        digits = 24'h0;
        #1;
        check("abort_e", e, 1'b0);
        check("abort_ready", ready, 1'b0);
        check("abort_busy", busy, 1'b1);
        repeat (3) @(negedge clk);
        log_d.delete(); log_rs.delete(); log_t.delete();
        log1_d.delete(); log1_rs.delete();
        rst_n = 1'b1;
        settle("reinit_done");
        check_init_log("reinit");

        // 5: single digit at the last column of row 0
        n = 0;
        while (!(ready1 && !busy1) && n < 300) begin @(negedge clk); n++; end
        check("d1_ready", ready1 && !busy1, 1'b1);
        log1_d.delete(); log1_rs.delete();
        digits1 = 4'hF;
        load1 = 1'b1;
        @(negedge clk);
        load1 = 1'b0;
        n = 0;
        while (busy1 && n < 300) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        check("d1_count", log1_d.size(), 2);
        if (log1_d.size() >= 2) begin
            check("d1_addr", {log1_rs[0], log1_d[0]}, 9'h08F);
            check("d1_char", {log1_rs[1], log1_d[1]}, 9'h146);
        end
        check("d1_busy_len", last_busy1_len, 2 * P);

        // 6: input change without a strobe
        log_d.delete(); log_rs.delete(); log_t.delete();
        digits = 24'h00000A;
        repeat (100) @(negedge clk);
`ifdef LCD_AUTO_REFRESH_EN
        check("auto_count", log_d.size(), 7);
        if (log_d.size() >= 7) check("auto_last", log_d[6], 8'h41);
`else
        check("no_auto_count", log_d.size(), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
